alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are even and 8..64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 in_valid_i  input  1  operation request.
REQ-006 in_ready_o  output  1  block can accept a request.
REQ-007 ctrl_i  input  4  opcode.
REQ-008 src1_i, src2_i  input  WIDTH  operands.
REQ-009 shamt_i  input  SHW  immediate shift amount.
REQ-010 out_valid_o  output  1  result registers hold a valid result.
REQ-011 out_ready_i  input  1  consumer takes the result.
REQ-012 result_o  output  WIDTH  registered result.
REQ-013 zero_o, ovf_o, div0_o  output  1 each  registered flags.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE; in_ready_o SHALL be 1 only in IDLE.
REQ-015 Accept SHALL occur when in_valid_i && in_ready_o; ctrl_i, src1_i, src2_i and shamt_i SHALL be captured at accept.
REQ-016 Single-cycle ops (accept, IDLE->DONE) SHALL raise out_valid_o on the cycle after accept:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB
  - 0111 SLT signed -> 1/0; 0101 SLTU unsigned -> 1/0
  - 0011 LUI: {src2[WIDTH/2-1:0], zeros}
  - 1000 SRA src2 by shamt_i; 1001 SRAV src2 by src1[SHW-1:0]
  - 1010 EQ: 1 if src1==src2
  - any other code: result 0
REQ-017 Multi-cycle ops (accept, IDLE->BUSY) SHALL use shift-add or restoring iteration:
  - 1011 MUL, low WIDTH bits of unsigned product; 1100 MULHU, high WIDTH bits
  - 1101 DIVU quotient; 1110 REMU remainder
REQ-018 BUSY SHALL last exactly WIDTH cycles, tracked by an iteration counter, then go to DONE; out_valid_o rises WIDTH+1 cycles after accept.
REQ-019 DIVU/REMU with src2==0 SHALL give quotient all-ones, remainder = src1 and div0_o=1; div0_o SHALL be 0 for every other case.
REQ-020 ovf_o SHALL flag signed two's-complement overflow for ADD/SUB only, 0 otherwise; zero_o SHALL equal (result_o==0).
REQ-021 In DONE, result_o and all flags SHALL hold stable while out_ready_i=0.
REQ-022 DONE->IDLE SHALL occur on out_valid_o && out_ready_i; out_valid_o SHALL drop on the next cycle, with no same-cycle re-accept.
REQ-023 in_valid_i SHALL be ignored in BUSY and DONE; operand inputs SHALL have no effect after accept.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH, with no saturation.

Reset
REQ-025 While rst_i=0, regardless of state:
  - state=IDLE, counter=0
  - result_o=0, zero_o=0, ovf_o=0, div0_o=0, out_valid_o=0, in_ready_o=0
REQ-026 The first rising edge after rst_i rises SHALL set in_ready_o=1; an in-flight operation is discarded and never delivered.

Verification (WIDTH=32)
REQ-027 ADD 0x7FFFFFFF+0x00000001 -> result_o=0x80000000, ovf_o=1, zero_o=0, out_valid_o 1 cycle after accept; SUB 5-5 -> result_o=0, zero_o=1.
REQ-028 MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU same operands -> 0xFFFFFFFE; out_valid_o exactly 33 cycles after accept; in_ready_o=0 throughout.
REQ-029 DIVU 100/7 -> 14 and REMU -> 2, both with div0_o=0; DIVU 5/0 -> 0xFFFFFFFF with div0_o=1; REMU 5/0 -> 5 with div0_o=1.
REQ-030 SRA 0x80000000 with shamt_i=4 -> 0xF8000000; SRAV with src1=36 -> 0xF8000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
REQ-031 out_ready_i held 0 for 10 cycles in DONE -> result_o and flags unchanged, in_ready_o=0, in_valid_i ignored; releasing it -> IDLE next cycle.
REQ-032 rst_i pulsed low during BUSY cycle 5 of a MUL -> all outputs 0 immediately (asynchronous); after release, no stale result appears and a new ADD completes correctly.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready request and response handshake.
// Logic and compare ops, ADD/SUB, LUI and arithmetic shifts finish one cycle
// after accept. MUL/MULHU use a shift-add loop and DIVU/REMU use restoring
// division. Both loops take WIDTH cycles in BUSY.
//
// Ports:
//   clk_i, rst_i               clock; asynchronous active-low reset
//   in_valid_i / in_ready_o    request handshake (ready only in IDLE)
//   ctrl_i, src1_i, src2_i,    opcode, operands and immediate shift amount,
//   shamt_i                    all captured at accept
//   out_valid_o / out_ready_i  response handshake
//   result_o, zero_o, ovf_o,   registered result and flags, held while DONE
//   div0_o
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o,
  output logic             div0_o
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LUI   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SRAV  = 4'b1001;
  localparam logic [3:0] OP_EQ    = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_hi;   // MUL: upper product half; DIV: partial remainder
  logic [WIDTH-1:0] r_lo;   // MUL: multiplier/lower half; DIV: dividend/quotient
  logic [WIDTH-1:0] r_b;    // multiplicand or divisor
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero, r_ovf, r_div0;

  // single-cycle result, evaluated straight from the request inputs
  logic [WIDTH-1:0] w_sum, w_dif, w_res1;
  logic             w_ovf1, w_start_mc;

  always_comb begin
    w_sum  = src1_i + src2_i;
    w_dif  = src1_i - src2_i;
    w_res1 = '0;
    w_ovf1 = 1'b0;
    case (ctrl_i)
      OP_AND:  w_res1 = src1_i & src2_i;
      OP_OR:   w_res1 = src1_i | src2_i;
      OP_ADD: begin
        w_res1 = w_sum;
        w_ovf1 = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (w_sum[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        w_res1 = w_dif;
        w_ovf1 = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (w_dif[WIDTH-1] != src1_i[WIDTH-1]);
      end
      OP_SLT:  w_res1 = WIDTH'($signed(src1_i) < $signed(src2_i));
      OP_SLTU: w_res1 = WIDTH'(src1_i < src2_i);
      OP_LUI:  w_res1 = {src2_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SRA:  w_res1 = $signed(src2_i) >>> shamt_i;
      OP_SRAV: w_res1 = $signed(src2_i) >>> src1_i[SHW-1:0];
      OP_EQ:   w_res1 = WIDTH'(src1_i == src2_i);
      default: w_res1 = '0;
    endcase
  end

  assign w_start_mc = (ctrl_i == OP_MUL) || (ctrl_i == OP_MULHU) ||
                      (ctrl_i == OP_DIVU) || (ctrl_i == OP_REMU);

  // one iteration of the multi-cycle datapath
  logic             w_is_mul, w_dge, w_last;
  logic [WIDTH:0]   w_macc, w_dsh;
  logic [WIDTH-1:0] w_ddif, w_nhi, w_nlo, w_mres;

  assign w_is_mul = (r_op == OP_MUL) || (r_op == OP_MULHU);
  assign w_last   = (r_cnt == CW'(WIDTH-1));

  always_comb begin
    w_macc = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_dsh  = {r_hi, r_lo[WIDTH-1]};
    w_dge  = (w_dsh >= {1'b0, r_b});
    // the true difference is below 2^WIDTH whenever it is used, so WIDTH bits suffice
    w_ddif = w_dsh[WIDTH-1:0] - r_b;
    if (w_is_mul) begin
      w_nhi = w_macc[WIDTH:1];
      w_nlo = {w_macc[0], r_lo[WIDTH-1:1]};
    end else begin
      // a zero divisor always "fits": quotient all-ones, remainder = dividend
      w_nhi = w_dge ? w_ddif : w_dsh[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_dge};
    end
    w_mres = ((r_op == OP_MUL) || (r_op == OP_DIVU)) ? w_nlo : w_nhi;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_div0      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i && r_in_ready) begin
            r_op       <= ctrl_i;
            r_in_ready <= 1'b0;
            if (w_start_mc) begin
              r_hi    <= '0;
              r_lo    <= src1_i;
              r_b     <= src2_i;
              r_cnt   <= '0;
              r_state <= BUSY;
            end else begin
              r_result    <= w_res1;
              r_zero      <= (w_res1 == '0);
              r_ovf       <= w_ovf1;
              r_div0      <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end else begin
            // also covers the first edge after reset release
            r_in_ready <= 1'b1;
          end
        end
        BUSY: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_result    <= w_mres;
            r_zero      <= (w_mres == '0);
            r_ovf       <= 1'b0;
            r_div0      <= !w_is_mul && (r_b == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;
  assign zero_o      = r_zero;
  assign ovf_o       = r_ovf;
  assign div0_o      = r_div0;

endmodule
